// File: rtl/fabric_config_pkg.sv
// Shared constants and types for the fabric configuration controller.
// Packet words, opcodes, error codes, FSM states and header layout.
package fabric_config_pkg;

  localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_DESYNC = 8'h02;

  localparam int HDR_OP_MSB  = 31;
  localparam int HDR_OP_LSB  = 24;
  localparam int HDR_CNT_MSB = 23;
  localparam int HDR_CNT_LSB = 16;
  localparam int HDR_ADR_MSB = 15;
  localparam int HDR_ADR_LSB = 0;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_OPCODE  = 2'd1,
    ERR_RANGE   = 2'd2,
    ERR_OVERRUN = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2,
    ST_STROBE = 2'd3
  } state_e;

endpackage

// File: rtl/fabric_config_ctrl.sv
// Packet parser and frame assembler feeding the fabric config chain.
// Collects NUM_ROWS words per frame and strobes them into the fabric.
module fabric_config_ctrl
  import fabric_config_pkg::*;
#(
  parameter int NUM_ROWS      = 4,
  parameter int FRAME_AW      = 8,
  parameter int NUM_FRAMES    = 200,
  parameter int STROBE_CYCLES = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic [31:0]              word_data_i,
  input  logic                     word_valid_i,
  output logic [NUM_ROWS*32-1:0]   frame_data_o,
  output logic [FRAME_AW-1:0]      frame_addr_o,
  output logic                     frame_strobe_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     error_o,
  output logic [1:0]               err_code_o
);

  localparam int FW  = NUM_ROWS * 32;
  localparam int WCW = $clog2(NUM_ROWS) + 1;
  localparam logic [WCW-1:0] W_LAST = WCW'(NUM_ROWS - 1);
  localparam logic [3:0] S_LAST = 4'(STROBE_CYCLES - 1);
  localparam logic [16:0] FRAMES_L = 17'(NUM_FRAMES);

  state_e            state_q, state_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic [FRAME_AW-1:0] addr_q, addr_d;
  logic [7:0]        rem_q, rem_d;
  logic [WCW-1:0]    wcnt_q, wcnt_d;
  logic [3:0]        scnt_q, scnt_d;
  logic              ovr_q, ovr_d;
  logic              strobe_q, strobe_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  err_code_e         code_q, code_d;

  logic [7:0]  hdr_op;
  logic [7:0]  hdr_cnt;
  logic [15:0] hdr_start;
  logic [16:0] hdr_end;
  logic        hdr_hi;
  logic        is_sync;

  assign hdr_op    = word_data_i[HDR_OP_MSB:HDR_OP_LSB];
  assign hdr_cnt   = word_data_i[HDR_CNT_MSB:HDR_CNT_LSB];
  assign hdr_start = word_data_i[HDR_ADR_MSB:HDR_ADR_LSB];
  assign hdr_end   = {1'b0, hdr_start} + {9'd0, hdr_cnt} + 17'd1;
  assign hdr_hi    = (hdr_start >> FRAME_AW) != 16'd0;
  assign is_sync   = word_data_i == SYNC_WORD;

  // Next-state, datapath and flag updates for the packet FSM.
  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    wcnt_d   = wcnt_q;
    scnt_d   = scnt_q;
    ovr_d    = ovr_q;
    done_d   = 1'b0;
    err_d    = err_q;
    code_d   = code_q;
    if (!enable_i) begin
      state_d = ST_IDLE;
      wcnt_d  = '0;
      scnt_d  = '0;
      ovr_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (word_valid_i && is_sync) begin
            err_d   = 1'b0;
            code_d  = ERR_NONE;
            state_d = ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (word_valid_i) begin
            unique case (1'b1)
              is_sync: ;
              hdr_op == OP_NOP: ;
              hdr_op == OP_WRITE: begin
                if (hdr_end > FRAMES_L || hdr_hi) begin
                  err_d   = 1'b1;
                  code_d  = ERR_RANGE;
                  state_d = ST_IDLE;
                end else begin
                  addr_d  = hdr_start[FRAME_AW-1:0];
                  rem_d   = hdr_cnt;
                  wcnt_d  = '0;
                  state_d = ST_DATA;
                end
              end
              hdr_op == OP_DESYNC: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end
              default: begin
                err_d   = 1'b1;
                code_d  = ERR_OPCODE;
                state_d = ST_IDLE;
              end
            endcase
          end
        end
        ST_DATA: begin
          if (word_valid_i) begin
            frame_d = {frame_q[FW-33:0], word_data_i};
            if (wcnt_q == W_LAST) begin
              wcnt_d  = '0;
              scnt_d  = '0;
              state_d = ST_STROBE;
            end else begin
              wcnt_d = wcnt_q + 1'b1;
            end
          end
        end
        ST_STROBE: begin
          if (word_valid_i) begin
            ovr_d  = 1'b1;
            err_d  = 1'b1;
            code_d = ERR_OVERRUN;
          end
          if (scnt_q == S_LAST) begin
            scnt_d = '0;
            if (ovr_q || word_valid_i) begin
              ovr_d   = 1'b0;
              state_d = ST_IDLE;
            end else if (rem_q == 8'd0) begin
              state_d = ST_HEADER;
            end else begin
              rem_d   = rem_q - 8'd1;
              addr_d  = addr_q + 1'b1;
              state_d = ST_DATA;
            end
          end else begin
            scnt_d = scnt_q + 4'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    strobe_d = state_d == ST_STROBE;
  end

  // State and datapath registers; reset clears frame and strobe at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      frame_q  <= '0;
      addr_q   <= '0;
      rem_q    <= '0;
      wcnt_q   <= '0;
      scnt_q   <= '0;
      ovr_q    <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      wcnt_q   <= wcnt_d;
      scnt_q   <= scnt_d;
      ovr_q    <= ovr_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  assign frame_data_o   = frame_q;
  assign frame_addr_o   = addr_q;
  assign frame_strobe_o = strobe_q;
  assign busy_o         = state_q != ST_IDLE;
  assign done_o         = done_q;
  assign error_o        = err_q;
  assign err_code_o     = code_q;

endmodule

// File: tb/tb_fabric_config_ctrl.sv
// Directed bench for fabric_config_ctrl with a frame scoreboard.
// Strobed frames are captured by a monitor and matched in order.
module tb_fabric_config_ctrl;

  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  typedef struct {
    logic [7:0]  addr;
    logic [63:0] data;
    int          len;
    bit          stable;
  } frm_t;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        enable_i;
  logic [31:0] word_data_i;
  logic        word_valid_i;
  logic [63:0] frame_data_o;
  logic [7:0]  frame_addr_o;
  logic        frame_strobe_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [1:0]  err_code_o;

  int ntests = 0;
  int nfail  = 0;

  frm_t exp_q[$];
  frm_t obs_q[$];
  frm_t m_cur;
  int   m_len = 0;

  fabric_config_ctrl #(
    .NUM_ROWS(2),
    .FRAME_AW(8),
    .NUM_FRAMES(200),
    .STROBE_CYCLES(2)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .enable_i(enable_i),
    .word_data_i(word_data_i),
    .word_valid_i(word_valid_i),
    .frame_data_o(frame_data_o),
    .frame_addr_o(frame_addr_o),
    .frame_strobe_o(frame_strobe_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .error_o(error_o),
    .err_code_o(err_code_o)
  );

  always #5 clk = ~clk;

  // Capture each strobe burst: address/data at rise, length, stability.
  always @(negedge clk) begin
    if (frame_strobe_o === 1'b1) begin
      if (m_len == 0) begin
        m_cur.addr   = frame_addr_o;
        m_cur.data   = frame_data_o;
        m_cur.stable = 1'b1;
      end else if (frame_addr_o !== m_cur.addr ||
                   frame_data_o !== m_cur.data) begin
        m_cur.stable = 1'b0;
      end
      m_len++;
    end else if (m_len > 0) begin
      m_cur.len = m_len;
      obs_q.push_back(m_cur);
      m_len = 0;
    end
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(logic [31:0] w, int gap);
    @(negedge clk);
    word_data_i  = w;
    word_valid_i = 1'b1;
    @(negedge clk);
    word_valid_i = 1'b0;
    repeat (gap) @(negedge clk);
    #1;
  endtask

  task automatic wait_cyc(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push_exp(logic [7:0] a, logic [63:0] d, int len);
    frm_t e;
    e.addr   = a;
    e.data   = d;
    e.len    = len;
    e.stable = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(string tag);
    frm_t e;
    frm_t o;
    int t = 0;
    while (obs_q.size() == 0 && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    e = exp_q.pop_front();
    chk({tag, "_present"}, obs_q.size() > 0, 1);
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      chk({tag, "_addr"}, o.addr, e.addr);
      chk({tag, "_data"}, o.data, e.data);
      chk({tag, "_len"}, o.len, e.len);
      chk({tag, "_stable"}, o.stable, e.stable);
    end
  endtask

  initial begin
    logic [31:0] w[6];
    rst_ni       = 1'b0;
    enable_i     = 1'b1;
    word_data_i  = '0;
    word_valid_i = 1'b0;
    wait_cyc(3);

    chk("rst_strobe", frame_strobe_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", error_o, 0);
    chk("rst_code", err_code_o, 0);
    chk("rst_data", frame_data_o, 0);
    chk("rst_addr", frame_addr_o, 0);
    rst_ni = 1'b1;
    wait_cyc(2);

    send(SYNC, 2);
    chk("sync_busy", busy_o, 1);
    send(32'h0100_0005, 2);
    push_exp(8'h05, 64'hAAAAAAAA_55555555, 2);
    send(32'hAAAA_AAAA, 6);
    send(32'h5555_5555, 0);
    chk("first_strobe_rise", frame_strobe_o, 1);
    wait_cyc(1);
    chk("strobe_cyc2", frame_strobe_o, 1);
    wait_cyc(1);
    chk("strobe_fall", frame_strobe_o, 0);
    pop_check("single");
    chk("hdr_busy", busy_o, 1);
    send(32'h0200_0000, 0);
    chk("done_pulse", done_o, 1);
    wait_cyc(1);
    chk("done_clear", done_o, 0);
    chk("desync_busy", busy_o, 0);

    for (int i = 0; i < 6; i++) w[i] = 32'h1000_0000 + 32'(i * 3);
    send(SYNC, 2);
    send(32'h0102_0010, 2);
    for (int i = 0; i < 3; i++)
      push_exp(8'(8'h10 + i), {w[2*i], w[2*i+1]}, 2);
    for (int i = 0; i < 6; i++) send(w[i], 6);
    pop_check("multi0");
    pop_check("multi1");
    pop_check("multi2");
    chk("multi_hdr", busy_o, 1);
    send(32'h0000_0000, 2);
    chk("nop_busy", busy_o, 1);
    send(SYNC, 2);
    chk("sync_nop_busy", busy_o, 1);
    chk("sync_nop_err", error_o, 0);
    send(32'h0200_0000, 2);

    send(SYNC, 2);
    send(32'h0100_00C8, 0);
    chk("range_err", error_o, 1);
    chk("range_code", err_code_o, 2);
    wait_cyc(1);
    chk("range_idle", busy_o, 0);
    send(SYNC, 2);
    chk("sync_clr_err", error_o, 0);
    chk("sync_clr_code", err_code_o, 0);
    send(32'h0100_00C7, 2);
    push_exp(8'hC7, 64'h0000_0001_0000_0002, 2);
    send(32'h0000_0001, 6);
    send(32'h0000_0002, 6);
    pop_check("last_addr");
    send(32'h0200_0000, 2);

    send(SYNC, 2);
    send(32'h7F00_0000, 0);
    chk("opc_err", error_o, 1);
    chk("opc_code", err_code_o, 1);
    wait_cyc(1);
    chk("opc_idle", busy_o, 0);

    send(SYNC, 2);
    send(32'h0100_0003, 2);
    push_exp(8'h03, 64'h1111_2222_3333_4444, 2);
    send(32'h1111_2222, 6);
    send(32'h3333_4444, 0);
    send(32'h9999_9999, 0);
    chk("ovr_err", error_o, 1);
    chk("ovr_code", err_code_o, 3);
    pop_check("overrun");
    chk("ovr_idle", busy_o, 0);

    send(SYNC, 2);
    send(32'h0100_0001, 2);
    send(32'hDEAD_BEEF, 1);
    @(negedge clk);
    enable_i = 1'b0;
    wait_cyc(1);
    chk("abort_busy", busy_o, 0);
    chk("abort_keep", frame_data_o[31:0], 32'hDEAD_BEEF);
    send(SYNC, 2);
    chk("dis_ignore", busy_o, 0);
    wait_cyc(6);
    chk("abort_nostrobe", obs_q.size(), 0);
    enable_i = 1'b1;
    wait_cyc(1);

    send(SYNC, 2);
    send(32'h0100_0007, 2);
    push_exp(8'h07, 64'hCAFE_0000_0000_BEEF, 1);
    send(32'hCAFE_0000, 6);
    send(32'h0000_BEEF, 0);
    chk("rst_mid_pre", frame_strobe_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_drop", frame_strobe_o, 0);
    chk("rst_mid_data", frame_data_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    wait_cyc(2);
    pop_check("rst_partial");
    rst_ni = 1'b1;
    wait_cyc(2);

    send(32'h1234_5678, 2);
    send(32'h0100_0000, 2);
    chk("noise_busy", busy_o, 0);
    chk("noise_err", error_o, 0);
    chk("noise_code", err_code_o, 0);
    wait_cyc(4);
    chk("obs_empty", obs_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
